csc_rgb2ycbcr_pipe: RTL and testbench

Parametrised RGB→YCbCr colour-space converter for the video pipeline, sitting directly behind the camera/RGB source and ahead of the Y-domain filters (gray, Sobel, binarisation). It supports configurable pixel width, coefficient precision, and four run-time conversion modes (BT.601/BT.709, full/studio range). It also provides rounding, saturation, and frame-aligned mode switching, with the sync signals delayed to match the data path.

---
 rtl/csc_pkg.sv | 75 +++++++
 rtl/csc_sync_delay.sv | 28 ++
 rtl/csc_rgb2ycbcr_pipe.sv | 197 +++++++++++++++++++
 tb/tb_csc_rgb2ycbcr_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared types and constants for the RGB->YCbCr converter: mode encoding,
// coefficient generator, pipeline latency and studio-range clamp limits.
package csc_pkg;

    typedef enum logic [1:0] {
        CSC_601_FULL   = 2'd0,
        CSC_601_STUDIO = 2'd1,
        CSC_709_FULL   = 2'd2,
        CSC_709_STUDIO = 2'd3
    } csc_mode_e;

    localparam int LAT = 4;

    // 8-bit studio limits; scaled by 2^(DATA_W-8) at the point of use
    localparam int STUDIO_Y_MIN = 16;
    localparam int STUDIO_Y_MAX = 235;
    localparam int STUDIO_C_MIN = 16;
    localparam int STUDIO_C_MAX = 240;

    localparam int COEF_SW = 16;

    // Row-major 3x3 signed matrix: [0..2] Y, [3..5] Cb, [6..8] Cr; columns R,G,B
    typedef logic [8:0][COEF_SW-1:0] coef_mat_t;

    function automatic logic csc_is_studio(csc_mode_e m);
        return (m == CSC_601_STUDIO) || (m == CSC_709_STUDIO);
    endfunction

    function automatic longint csc_rdiv(longint n, longint d);
        if (n >= 0) return (n + d / 2) / d;
        else        return -((-n + d / 2) / d);
    endfunction

    // Reference coefficients are held in millionths. The G column absorbs the
    // rounding residue so each row sums exactly to its target.
    function automatic coef_mat_t csc_coefs(csc_mode_e mode, int coef_w);
        longint    s, kr, kb, cbr, crb, ny, nc, den;
        longint    yr, yb, yt, c_half, cb_r, cr_b;
        logic      studio;
        coef_mat_t m;
        s      = longint'(1) << coef_w;
        studio = csc_is_studio(mode);
        if ((mode == CSC_601_FULL) || (mode == CSC_601_STUDIO)) begin
            kr  = 299000;
            kb  = 114000;
            cbr = -168736;
            crb = -81312;
        end else begin
            kr  = 212600;
            kb  = 72200;
            cbr = -114572;
            crb = -45847;
        end
        ny     = studio ? 219 : 255;
        nc     = studio ? 224 : 255;
        den    = 255000000;
        yr     = csc_rdiv(kr * ny * s, den);
        yb     = csc_rdiv(kb * ny * s, den);
        yt     = csc_rdiv(ny * s, 255);
        c_half = csc_rdiv(500000 * nc * s, den);
        cb_r   = csc_rdiv(cbr * nc * s, den);
        cr_b   = csc_rdiv(crb * nc * s, den);
        m[0] = COEF_SW'(yr);
        m[1] = COEF_SW'(yt - yr - yb);
        m[2] = COEF_SW'(yb);
        m[3] = COEF_SW'(cb_r);
        m[4] = COEF_SW'(-cb_r - c_half);
        m[5] = COEF_SW'(c_half);
        m[6] = COEF_SW'(c_half);
        m[7] = COEF_SW'(-c_half - cr_b);
        m[8] = COEF_SW'(cr_b);
        return m;
    endfunction

endpackage

// File: rtl/csc_sync_delay.sv
// Parametrised-depth shift register with async reset; carries the sync
// bits and the pixel's mode alongside the data pipeline.
module csc_sync_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_data = r_sr[DEPTH-1];

endmodule

// File: rtl/csc_rgb2ycbcr_pipe.sv
// Four-stage RGB->YCbCr converter with frame-aligned mode switching.
// Optional macro CSC_ROUND_EN selects round-half-up instead of truncation.
module csc_rgb2ycbcr_pipe
    import csc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_sel,
    input  logic              per_img_vsync,
    input  logic              per_img_href,
    input  logic              per_img_valid,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    output logic              post_img_vsync,
    output logic              post_img_href,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_Y,
    output logic [DATA_W-1:0] post_img_Cb,
    output logic [DATA_W-1:0] post_img_Cr,
    output logic [1:0]        post_img_mode
);

    localparam int PW     = DATA_W + COEF_W + 2;
    localparam int SW     = PW + 2;
    localparam int QW     = SW - COEF_W;
    localparam int SYNC_W = 5;
    localparam int SC     = 1 << (DATA_W - 8);

    localparam coef_mat_t COEF_601F = csc_coefs(CSC_601_FULL, COEF_W);
    localparam coef_mat_t COEF_601S = csc_coefs(CSC_601_STUDIO, COEF_W);
    localparam coef_mat_t COEF_709F = csc_coefs(CSC_709_FULL, COEF_W);
    localparam coef_mat_t COEF_709S = csc_coefs(CSC_709_STUDIO, COEF_W);

    localparam logic signed [SW-1:0] OFF_Y_STUDIO = SW'(16 << (DATA_W - 8 + COEF_W));
    localparam logic signed [SW-1:0] OFF_C        = SW'(1 << (DATA_W - 1 + COEF_W));

    localparam logic signed [QW-1:0] LIM_FULL_HI = QW'((1 << DATA_W) - 1);
    localparam logic signed [QW-1:0] LIM_SY_LO   = QW'(STUDIO_Y_MIN * SC);
    localparam logic signed [QW-1:0] LIM_SY_HI   = QW'(STUDIO_Y_MAX * SC);
    localparam logic signed [QW-1:0] LIM_SC_LO   = QW'(STUDIO_C_MIN * SC);
    localparam logic signed [QW-1:0] LIM_SC_HI   = QW'(STUDIO_C_MAX * SC);

    logic                    r_vsync_d;
    csc_mode_e               r_mode_q;
    logic                    w_vsync_rise;
    csc_mode_e               w_mode_cur;
    csc_mode_e               w_mode_s2;
    csc_mode_e               w_mode_s4;
    coef_mat_t               w_coef;
    logic signed [PW-1:0]    w_cf   [9];
    logic signed [PW-1:0]    w_pix  [3];
    logic signed [SW-1:0]    w_off  [3];
    logic signed [QW-1:0]    w_lo   [3];
    logic signed [QW-1:0]    w_hi   [3];
    logic [SYNC_W-1:0]       w_sync0, w_sync1, w_sync3, w_sync4;

    logic signed [PW-1:0]    r_prod [9];
    logic signed [SW-1:0]    r_sum  [3];
    logic signed [QW-1:0]    r_q    [3];
    logic [DATA_W-1:0]       r_out  [3];

    // The pixel sampled on the vsync rising edge already uses the new mode
    assign w_vsync_rise = per_img_vsync & ~r_vsync_d;
    assign w_mode_cur   = w_vsync_rise ? csc_mode_e'(mode_sel) : r_mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_mode_q  <= CSC_601_FULL;
        end else begin
            r_vsync_d <= per_img_vsync;
            r_mode_q  <= w_mode_cur;
        end
    end

    always_comb begin
        w_coef = COEF_601F;
        case (w_mode_cur)
            CSC_601_FULL:   w_coef = COEF_601F;
            CSC_601_STUDIO: w_coef = COEF_601S;
            CSC_709_FULL:   w_coef = COEF_709F;
            CSC_709_STUDIO: w_coef = COEF_709S;
            default:        w_coef = COEF_601F;
        endcase
        for (int i = 0; i < 9; i++) begin
            w_cf[i] = PW'($signed(w_coef[i]));
        end
    end

    assign w_pix[0] = $signed(PW'(per_img_red));
    assign w_pix[1] = $signed(PW'(per_img_green));
    assign w_pix[2] = $signed(PW'(per_img_blue));

    // Sync/mode travel in three chained segments so the mode is tapped where
    // stage 2 (offset) and stage 4 (clamp) need it.
    assign w_sync0 = {per_img_vsync, per_img_href, per_img_valid, w_mode_cur};

    csc_sync_delay #(.DEPTH(1), .WIDTH(SYNC_W)) u_sync_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_sync0),
        .o_data (w_sync1)
    );

    csc_sync_delay #(.DEPTH(LAT - 2), .WIDTH(SYNC_W)) u_sync_s3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_sync1),
        .o_data (w_sync3)
    );

    csc_sync_delay #(.DEPTH(1), .WIDTH(SYNC_W)) u_sync_s4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_sync3),
        .o_data (w_sync4)
    );

    assign w_mode_s2 = csc_mode_e'(w_sync1[1:0]);
    assign w_mode_s4 = csc_mode_e'(w_sync3[1:0]);

    always_comb begin
        w_off[0] = csc_is_studio(w_mode_s2) ? OFF_Y_STUDIO : '0;
        w_off[1] = OFF_C;
        w_off[2] = OFF_C;
    end

    always_comb begin
        if (csc_is_studio(w_mode_s4)) begin
            w_lo[0] = LIM_SY_LO;
            w_hi[0] = LIM_SY_HI;
            w_lo[1] = LIM_SC_LO;
            w_hi[1] = LIM_SC_HI;
            w_lo[2] = LIM_SC_LO;
            w_hi[2] = LIM_SC_HI;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                w_lo[ch] = '0;
                w_hi[ch] = LIM_FULL_HI;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int row = 0; row < 3; row++) begin
            for (int col = 0; col < 3; col++) begin
                r_prod[3*row+col] <= w_pix[col] * w_cf[3*row+col];
            end
        end
        for (int ch = 0; ch < 3; ch++) begin
            r_sum[ch] <= SW'(r_prod[3*ch]) + SW'(r_prod[3*ch+1])
                       + SW'(r_prod[3*ch+2]) + w_off[ch];
        end
    end

`ifdef CSC_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(1 << (COEF_W - 1));

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            r_q[ch] <= QW'((r_sum[ch] + RND) >>> COEF_W);
        end
    end
`else
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            r_q[ch] <= QW'(r_sum[ch] >>> COEF_W);
        end
    end
`endif

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            if (r_q[ch] < w_lo[ch])
                r_out[ch] <= w_lo[ch][DATA_W-1:0];
            else if (r_q[ch] > w_hi[ch])
                r_out[ch] <= w_hi[ch][DATA_W-1:0];
            else
                r_out[ch] <= r_q[ch][DATA_W-1:0];
        end
    end

    assign post_img_vsync = w_sync4[4];
    assign post_img_href  = w_sync4[3];
    assign post_img_valid = w_sync4[2];
    assign post_img_mode  = w_sync4[1:0];

    // Data registers are unreset; the valid gate keeps outputs clean
    assign post_img_Y  = post_img_valid ? r_out[0] : '0;
    assign post_img_Cb = post_img_valid ? r_out[1] : '0;
    assign post_img_Cr = post_img_valid ? r_out[2] : '0;

endmodule

// File: tb/tb_csc_rgb2ycbcr_pipe.sv
// Directed and random checks of csc_rgb2ycbcr_pipe (DATA_W=8, COEF_W=8)
// against hand values and an independent per-pixel reference model.
module tb_csc_rgb2ycbcr_pipe;

    localparam int DW    = 8;
    localparam int PIPE  = 4;
    localparam int HN    = 2048;

`ifdef CSC_ROUND_EN
    localparam int RED_Y601 = 77;
    localparam int RED_Y709 = 54;
`else
    localparam int RED_Y601 = 76;
    localparam int RED_Y709 = 53;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode_sel = '0;
    logic          per_img_vsync = 1'b0, per_img_href = 1'b0, per_img_valid = 1'b0;
    logic [DW-1:0] per_img_red = '0, per_img_green = '0, per_img_blue = '0;
    logic          post_img_vsync, post_img_href, post_img_valid;
    logic [DW-1:0] post_img_Y, post_img_Cb, post_img_Cr;
    logic [1:0]    post_img_mode;

    always #5 clk = ~clk;

    csc_rgb2ycbcr_pipe #(.DATA_W(DW), .COEF_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_sel       (mode_sel),
        .per_img_vsync  (per_img_vsync),
        .per_img_href   (per_img_href),
        .per_img_valid  (per_img_valid),
        .per_img_red    (per_img_red),
        .per_img_green  (per_img_green),
        .per_img_blue   (per_img_blue),
        .post_img_vsync (post_img_vsync),
        .post_img_href  (post_img_href),
        .post_img_valid (post_img_valid),
        .post_img_Y     (post_img_Y),
        .post_img_Cb    (post_img_Cb),
        .post_img_Cr    (post_img_Cr),
        .post_img_mode  (post_img_mode)
    );

    // Hand-derived Q1.8 matrices, rows Y/Cb/Cr, columns R/G/B
    int cf [4][9] = '{
        '{77, 150, 29, -43, -85, 128, 128, -107, -21},
        '{66, 129, 25, -38, -74, 112, 112,  -94, -18},
        '{54, 184, 18, -29, -99, 128, 128, -116, -12},
        '{47, 157, 16, -26, -86, 112, 112, -102, -10}
    };

    int n_vec = 0, n_err = 0;
    int k = 0, k0 = 0, n_vout = 0;
    int m_mode = 0;
    bit m_vs = 1'b0;
    bit e_vs [HN], e_hs [HN], e_v [HN], h_en [HN];
    int e_md [HN], e_y [HN], e_cb [HN], e_cr [HN];
    int h_y [HN], h_cb [HN], h_cr [HN], h_md [HN];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, k, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vsync"}, int'(post_img_vsync), 0);
        chk({tag, "_href"},  int'(post_img_href), 0);
        chk({tag, "_valid"}, int'(post_img_valid), 0);
        chk({tag, "_mode"},  int'(post_img_mode), 0);
        chk({tag, "_Y"},     int'(post_img_Y), 0);
        chk({tag, "_Cb"},    int'(post_img_Cb), 0);
        chk({tag, "_Cr"},    int'(post_img_Cr), 0);
    endtask

    function automatic int csc_ref(input int md, input int ch, input int r, input int g, input int b);
        int  s, lo, hi;
        bit  st;
        st = (md == 1) || (md == 3);
        s  = r * cf[md][3*ch] + g * cf[md][3*ch+1] + b * cf[md][3*ch+2];
        s += ((ch == 0) ? (st ? 16 : 0) : 128) * 256;
`ifdef CSC_ROUND_EN
        s += 128;
`endif
        s  = s >>> 8;
        lo = st ? 16 : 0;
        hi = st ? ((ch == 0) ? 235 : 240) : 255;
        if (s < lo) s = lo;
        if (s > hi) s = hi;
        return s;
    endfunction

    // One pixel clock: check the output due from 4 cycles ago, then drive
    task automatic cyc(input bit vs, input bit hs, input bit v,
                       input int r, input int g, input int b, input int msel);
        int j;
        @(negedge clk);
        j = k - PIPE;
        if (post_img_valid === 1'b1) n_vout++;
        if (j >= k0) begin
            chk("vsync", int'(post_img_vsync), int'(e_vs[j]));
            chk("href",  int'(post_img_href),  int'(e_hs[j]));
            chk("valid", int'(post_img_valid), int'(e_v[j]));
            chk("mode",  int'(post_img_mode),  e_md[j]);
            chk("Y",     int'(post_img_Y),     e_y[j]);
            chk("Cb",    int'(post_img_Cb),    e_cb[j]);
            chk("Cr",    int'(post_img_Cr),    e_cr[j]);
            if (h_en[j]) begin
                chk("hand_Y",    int'(post_img_Y),    h_y[j]);
                chk("hand_Cb",   int'(post_img_Cb),   h_cb[j]);
                chk("hand_Cr",   int'(post_img_Cr),   h_cr[j]);
                chk("hand_mode", int'(post_img_mode), h_md[j]);
                chk("hand_valid", int'(post_img_valid), 1);
            end
        end else begin
            chk_zero("fill");
        end
        per_img_vsync = vs;
        per_img_href  = hs;
        per_img_valid = v;
        per_img_red   = DW'(r);
        per_img_green = DW'(g);
        per_img_blue  = DW'(b);
        mode_sel      = 2'(msel);
        if (vs && !m_vs) m_mode = msel;
        m_vs    = vs;
        e_vs[k] = vs;
        e_hs[k] = hs;
        e_v[k]  = v;
        e_md[k] = m_mode;
        e_y[k]  = v ? csc_ref(m_mode, 0, r, g, b) : 0;
        e_cb[k] = v ? csc_ref(m_mode, 1, r, g, b) : 0;
        e_cr[k] = v ? csc_ref(m_mode, 2, r, g, b) : 0;
        h_en[k] = 1'b0;
        k++;
    endtask

    task automatic hand(input int y, input int cb, input int cr, input int md);
        h_en[k-1] = 1'b1;
        h_y[k-1]  = y;
        h_cb[k-1] = cb;
        h_cr[k-1] = cr;
        h_md[k-1] = md;
    endtask

    task automatic model_reset();
        k0     = k;
        m_mode = 0;
        m_vs   = 1'b0;
        n_vout = 0;
    endtask

    initial begin
        #1;
        chk_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();

        // Mode 0 frame: white, red, then a mid-frame request for mode 2
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 255, 255, 255, 0);  hand(255, 128, 128, 0);
        cyc(1, 1, 1, 255, 0, 0, 0);      hand(RED_Y601, 85, 255, 0);
        cyc(1, 1, 0, 255, 255, 255, 2);
        cyc(1, 1, 1, 255, 0, 0, 2);      hand(RED_Y601, 85, 255, 0);
        cyc(1, 1, 1, 255, 255, 255, 2);  hand(255, 128, 128, 0);

        // New frame picks up mode 2 on the very pixel sampled with the edge
        cyc(0, 0, 0, 0, 0, 0, 2);
        cyc(1, 1, 1, 255, 0, 0, 2);      hand(RED_Y709, 99, 255, 2);
        cyc(1, 1, 1, 255, 255, 255, 1);  hand(255, 128, 128, 2);

        // Studio range, 601
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 255, 255, 255, 1);  hand(235, 128, 128, 1);
        cyc(1, 1, 1, 0, 0, 0, 1);        hand(16, 128, 128, 1);
        cyc(1, 1, 0, 255, 255, 255, 1);
        cyc(1, 1, 1, 0, 0, 0, 1);        hand(16, 128, 128, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 100 + i, 150, 200, 1);

        // Reset during active video with pixels in flight
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #2;
        per_img_vsync = 1'b0;
        per_img_href  = 1'b0;
        per_img_valid = 1'b0;
        mode_sel      = 2'd0;
        rst_n         = 1'b1;
        model_reset();
        cyc(1, 1, 1, 255, 255, 255, 0);  hand(255, 128, 128, 0);
        cyc(1, 1, 1, 255, 0, 0, 0);      hand(RED_Y601, 85, 255, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);        hand(0, 128, 128, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("post_rst_vcount", n_vout, 3);

        // Random frames with valid gaps and mid-frame mode requests
        for (int i = 0; i < 1000; i++) begin
            bit vs, v;
            vs = (i % 250) < 240;
            v  = vs && (($urandom % 4) != 0);
            cyc(vs, v, v, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 3));
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
